m_csr_trap_unit: RTL and testbench

- Parametrised machine-mode CSR file and trap sequencer. Successor to the flat machine CSR array.
- Adds:
  - CSRRW/CSRRS/CSRRC read-modify-write.
  - WARL masking.
  - Architecturally correct mstatus MIE/MPIE/MPP trap entry and mret behaviour.
  - Prioritised machine interrupts (external, software, timer).
  - mcycle/minstret counters.
  - Direct/vectored mtvec target generation.
- Sits beside the decode/execute stages. The pipeline consumes its outputs as the redirect PC source and the interrupt request.

---
 rtl/m_csr_trap_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_m_csr_trap_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer.
// Holds mstatus/mie/mtvec/mepc/mcause/mtval/counters and drives trap redirects.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef M_STACK_HI
`define M_STACK_HI 32'h8001_0000
`endif

module m_csr_trap_unit #(
    parameter int          XLEN         = `XLEN_64b,
    parameter bit          HAS_COUNTERS = 1'b1,
    parameter bit          VECTORED_EN  = 1'b1,
    parameter logic [31:0] MSCRATCH_RST = `M_STACK_HI & 32'hffff_fffc,
    localparam int         W            = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic [11:0]  i_csr_addr,
    input  logic [1:0]   i_csr_op,
    input  logic [W-1:0] i_csr_wdata,
    output logic [W-1:0] o_csr_rdata,
    output logic         o_csr_illegal,
    input  logic         i_exc_valid,
    input  logic [4:0]   i_exc_code,
    input  logic [W-1:0] i_exc_pc,
    input  logic [W-1:0] i_exc_tval,
    input  logic         i_irq_ack,
    input  logic [W-1:0] i_irq_pc,
    input  logic         i_mret,
    input  logic         i_instr_retired,
    input  logic         i_irq_mext,
    input  logic         i_irq_msoft,
    input  logic         i_irq_mtimer,
    output logic         o_irq_req,
    output logic [W-1:0] o_trap_target,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mstatus,
    output logic [1:0]   o_UXL
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSTATUSH  = 12'h310;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam bit          RV32        = (W == 32);
    localparam logic [W-1:0] SCRATCH_RST = W'($signed(MSCRATCH_RST));
    localparam logic [W-1:0] MTVEC_MASK  = VECTORED_EN ? ~W'(2) : ~W'(3);
    localparam logic [W-1:0] MEPC_MASK   = ~W'(3);
    localparam logic [W-1:0] MCAUSE_MASK = {1'b1, {(W-6){1'b0}}, 5'h1f};
    localparam logic [11:0]  MIE_MASK    = 12'h888;

    logic         mie_b;
    logic         mpie_b;
    logic [11:0]  mie_r;
    logic [W-1:0] mtvec;
    logic [W-1:0] mscratch;
    logic [W-1:0] mepc;
    logic [W-1:0] mcause;
    logic [W-1:0] mtval;
    logic         mei_q;
    logic         msi_q;
    logic         mti_q;
    logic [63:0]  mcycle;
    logic [63:0]  minstret;

    logic [11:0]  mip_v;
    logic [11:0]  pend;
    logic         irq_on;
    logic [4:0]   irq_code;
    logic [63:0]  ms64;
    logic [W-1:0] mstatus_v;
    logic [W-1:0] misa_v;
    logic         known;
    logic         ro;
    logic [W-1:0] old;
    logic [W-1:0] wval;
    logic         access;
    logic         wr_req;
    logic         take_irq;
    logic         do_mret;
    logic         do_wr;
    logic [W-1:0] base;

    assign mip_v  = {mei_q, 3'b000, mti_q, 3'b000, msi_q, 3'b000};
    assign pend   = mie_r & mip_v;
    assign irq_on = mie_b & (|pend);

    always_comb begin
        irq_code = 5'd0;
        if (pend[11])
            irq_code = 5'd11;
        else if (pend[3])
            irq_code = 5'd3;
        else if (pend[7])
            irq_code = 5'd7;
    end

    always_comb begin
        ms64 = '0;
        ms64[12:11] = 2'b11;
        ms64[7] = mpie_b;
        ms64[3] = mie_b;
        if (!RV32) begin
            ms64[33:32] = 2'(XLEN);
            ms64[35:34] = 2'(XLEN);
        end
        mstatus_v = ms64[W-1:0];
        misa_v = '0;
        misa_v[W-1 -: 2] = 2'(XLEN);
        misa_v[8] = 1'b1;
    end

    always_comb begin
        known = 1'b0;
        ro    = 1'b0;
        old   = '0;
        case (i_csr_addr)
            A_MSTATUS:   begin known = 1'b1; old = mstatus_v; end
            A_MISA:      begin known = 1'b1; ro = 1'b1; old = misa_v; end
            A_MSTATUSH:  known = RV32;
            A_MIE:       begin known = 1'b1; old = W'(mie_r); end
            A_MTVEC:     begin known = 1'b1; old = mtvec; end
            A_MSCRATCH:  begin known = 1'b1; old = mscratch; end
            A_MEPC:      begin known = 1'b1; old = mepc; end
            A_MCAUSE:    begin known = 1'b1; old = mcause; end
            A_MTVAL:     begin known = 1'b1; old = mtval; end
            A_MIP:       begin known = 1'b1; ro = 1'b1; old = W'(mip_v); end
            A_MCYCLE:    begin known = HAS_COUNTERS; old = mcycle[W-1:0]; end
            A_MINSTRET:  begin known = HAS_COUNTERS; old = minstret[W-1:0]; end
            A_MCYCLEH:   begin known = HAS_COUNTERS & RV32; old = W'(mcycle[63:32]); end
            A_MINSTRETH: begin known = HAS_COUNTERS & RV32; old = W'(minstret[63:32]); end
            default:     ;
        endcase
    end

    always_comb begin
        case (i_csr_op)
            2'b10:   wval = old | i_csr_wdata;
            2'b11:   wval = old & ~i_csr_wdata;
            default: wval = i_csr_wdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so counters keep counting
    // and read-only CSRs stay readable.
    assign access = |i_csr_op;
    assign wr_req = (i_csr_op == 2'b01) | (i_csr_op[1] & (|i_csr_wdata));

    assign o_csr_illegal = access & (~known | (ro & wr_req));
    assign o_csr_rdata   = (access & ~o_csr_illegal) ? old : '0;

    assign take_irq = i_irq_ack & irq_on & ~i_exc_valid;
    assign do_mret  = i_mret & ~i_exc_valid & ~take_irq;
    assign do_wr    = wr_req & known & ~ro & ~i_exc_valid & ~take_irq & ~i_mret;

    assign o_irq_req     = irq_on & ~i_exc_valid;
    assign base          = mtvec & ~W'(3);
    assign o_trap_target = (mtvec[0] & take_irq) ? base + W'({irq_code, 2'b00}) : base;
    assign o_mepc        = mepc;
    assign o_mstatus     = mstatus_v;
    assign o_UXL         = 2'(XLEN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mie_b    <= 1'b0;
            mpie_b   <= 1'b1;
            mie_r    <= '0;
            mtvec    <= '0;
            mscratch <= SCRATCH_RST;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mei_q    <= 1'b0;
            msi_q    <= 1'b0;
            mti_q    <= 1'b0;
            mcycle   <= '0;
            minstret <= '0;
        end else if (i_clk_en) begin
            mei_q    <= i_irq_mext;
            msi_q    <= i_irq_msoft;
            mti_q    <= i_irq_mtimer;
            mcycle   <= mcycle + 64'd1;
            minstret <= minstret + 64'(i_instr_retired);
            if (i_exc_valid) begin
                mepc   <= i_exc_pc & MEPC_MASK;
                mcause <= W'(i_exc_code);
                mtval  <= i_exc_tval;
                mpie_b <= mie_b;
                mie_b  <= 1'b0;
            end else if (take_irq) begin
                mepc   <= i_irq_pc & MEPC_MASK;
                mcause <= {1'b1, {(W-6){1'b0}}, irq_code};
                mtval  <= '0;
                mpie_b <= mie_b;
                mie_b  <= 1'b0;
            end else if (do_mret) begin
                mie_b  <= mpie_b;
                mpie_b <= 1'b1;
            end else if (do_wr) begin
                case (i_csr_addr)
                    A_MSTATUS: begin
                        mie_b  <= wval[3];
                        mpie_b <= wval[7];
                    end
                    A_MIE:       mie_r    <= wval[11:0] & MIE_MASK;
                    A_MTVEC:     mtvec    <= wval & MTVEC_MASK;
                    A_MSCRATCH:  mscratch <= wval;
                    A_MEPC:      mepc     <= wval & MEPC_MASK;
                    A_MCAUSE:    mcause   <= wval & MCAUSE_MASK;
                    A_MTVAL:     mtval    <= wval;
                    A_MCYCLE:    mcycle   <= RV32 ? {mcycle[63:32], wval[31:0]} : 64'(wval);
                    A_MINSTRET:  minstret <= RV32 ? {minstret[63:32], wval[31:0]} : 64'(wval);
                    A_MCYCLEH:   mcycle   <= {wval[31:0], mcycle[31:0]};
                    A_MINSTRETH: minstret <= {wval[31:0], minstret[31:0]};
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_csr_trap_unit.sv
// Directed and randomized checks of m_csr_trap_unit in its 32-bit configuration.
module tb_m_csr_trap_unit;

    localparam int          W   = 32;
    localparam logic [31:0] SCR = 32'h8000_fff0;

    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b1;
    logic [11:0]  csr_addr = '0;
    logic [1:0]   csr_op = '0;
    logic [W-1:0] csr_wdata = '0;
    logic [W-1:0] csr_rdata;
    logic         csr_illegal;
    logic         exc_valid = 1'b0;
    logic [4:0]   exc_code = '0;
    logic [W-1:0] exc_pc = '0;
    logic [W-1:0] exc_tval = '0;
    logic         irq_ack = 1'b0;
    logic [W-1:0] irq_pc = '0;
    logic         mret = 1'b0;
    logic         instr_retired = 1'b0;
    logic         irq_mext = 1'b0;
    logic         irq_msoft = 1'b0;
    logic         irq_mtimer = 1'b0;
    logic         irq_req;
    logic [W-1:0] trap_target;
    logic [W-1:0] mepc;
    logic [W-1:0] mstatus;
    logic [1:0]   uxl;

    int n_cmp = 0;
    int n_bad = 0;

    m_csr_trap_unit #(
        .XLEN(1),
        .HAS_COUNTERS(1'b1),
        .VECTORED_EN(1'b1),
        .MSCRATCH_RST(SCR)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_clk_en(clk_en),
        .i_csr_addr(csr_addr),
        .i_csr_op(csr_op),
        .i_csr_wdata(csr_wdata),
        .o_csr_rdata(csr_rdata),
        .o_csr_illegal(csr_illegal),
        .i_exc_valid(exc_valid),
        .i_exc_code(exc_code),
        .i_exc_pc(exc_pc),
        .i_exc_tval(exc_tval),
        .i_irq_ack(irq_ack),
        .i_irq_pc(irq_pc),
        .i_mret(mret),
        .i_instr_retired(instr_retired),
        .i_irq_mext(irq_mext),
        .i_irq_msoft(irq_msoft),
        .i_irq_mtimer(irq_mtimer),
        .o_irq_req(irq_req),
        .o_trap_target(trap_target),
        .o_mepc(mepc),
        .o_mstatus(mstatus),
        .o_UXL(uxl)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic il);
        csr_op = op;
        csr_addr = a;
        csr_wdata = wd;
        #1;
        rd = csr_rdata;
        il = csr_illegal;
        tick();
        csr_op = 2'b00;
        csr_wdata = '0;
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic il;
        csr(RS, a, 32'h0, r, il);
        check(tag, r, exp);
    endtask

    logic [11:0] raddr [7] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
    logic [31:0] rmask [7] = '{32'h888, 32'hffff_fffd, 32'hffff_ffff, 32'hffff_fffc,
                               32'h8000_001f, 32'hffff_ffff, 32'h0};
    logic [31:0] mdl [7];

    initial begin
        logic [31:0] r;
        logic        il;
        logic [31:0] mip_m;
        logic [31:0] nv;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [2:0]  lines;
        logic [1:0]  op;
        logic        wr;
        int          k;

        // reset state, then counter behaviour with and without clock enable
        tick();
        tick();
        rst = 1'b0;
        clk_en = 1'b0;
        check("rst_irq_req", irq_req, 0);
        check("rst_mepc", mepc, 0);
        check("rst_target", trap_target, 0);
        check("rst_mstatus_out", mstatus, 32'h1880);
        check("uxl", uxl, 2'b01);
        rdchk("rst_mstatus", 12'h300, 32'h1880);
        rdchk("rst_mscratch", 12'h340, SCR);
        rdchk("rst_mcycle", 12'hB00, 0);
        clk_en = 1'b1;
        tick();
        tick();
        tick();
        clk_en = 1'b0;
        rdchk("mcycle_3", 12'hB00, 3);
        clk_en = 1'b1;

        // set/clear/write with WARL masking on mie
        csr(RS, 12'h304, 32'h888, r, il);
        check("mie_rs_old", r, 0);
        csr(RC, 12'h304, 32'h008, r, il);
        check("mie_rc_old", r, 32'h888);
        rdchk("mie_after_rc", 12'h304, 32'h880);
        csr(RW, 12'h304, 32'hffff, r, il);
        check("mie_rw_old", r, 32'h880);
        rdchk("mie_warl", 12'h304, 32'h888);

        // timer interrupt, vectored mtvec
        csr(RS, 12'h300, 32'h8, r, il);
        csr(RW, 12'h304, 32'h80, r, il);
        csr(RW, 12'h305, 32'h101, r, il);
        rdchk("mtvec", 12'h305, 32'h101);
        irq_mtimer = 1'b1;
        #1;
        check("irq_req_same_cycle", irq_req, 0);
        tick();
        check("irq_req_next_cycle", irq_req, 1);
        irq_ack = 1'b1;
        irq_pc = 32'h1006;
        #1;
        check("irq_target", trap_target, 32'h11c);
        tick();
        irq_ack = 1'b0;
        irq_mtimer = 1'b0;
        check("irq_mepc", mepc, 32'h1004);
        check("irq_mstatus", mstatus, 32'h1880);
        check("irq_req_masked", irq_req, 0);
        rdchk("irq_mcause", 12'h342, 32'h8000_0007);
        rdchk("irq_mtval", 12'h343, 0);

        // mret restores MIE from MPIE
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_mstatus", mstatus, 32'h1888);
        check("mret_mepc", mepc, 32'h1004);
        check("mret_no_irq", irq_req, 0);

        // exception beats a same-cycle CSR write
        exc_valid = 1'b1;
        exc_code = 5'd2;
        exc_pc = 32'h200;
        exc_tval = 32'hdead;
        csr_op = RW;
        csr_addr = 12'h340;
        csr_wdata = 32'h1234;
        #1;
        check("exc_target", trap_target, 32'h100);
        tick();
        exc_valid = 1'b0;
        csr_op = 2'b00;
        csr_wdata = '0;
        rdchk("exc_mcause", 12'h342, 2);
        rdchk("exc_mtval", 12'h343, 32'hdead);
        rdchk("exc_mscratch", 12'h340, SCR);
        check("exc_mepc", mepc, 32'h200);
        check("exc_mstatus", mstatus, 32'h1880);

        // 32-bit counter halves and carry
        csr(RW, 12'hB80, 32'h0, r, il);
        csr(RW, 12'hB00, 32'hffff_ffff, r, il);
        rdchk("mcycle_written", 12'hB00, 32'hffff_ffff);
        rdchk("mcycle_wrap", 12'hB00, 0);
        rdchk("mcycleh_carry", 12'hB80, 1);
        csr(RW, 12'hB02, 32'd5, r, il);
        instr_retired = 1'b1;
        tick();
        tick();
        instr_retired = 1'b0;
        rdchk("minstret", 12'hB02, 7);

        // illegal accesses
        csr(RW, 12'h3A0, 32'h5, r, il);
        check("unimpl_illegal", il, 1);
        check("unimpl_rdata", r, 0);
        csr(RS, 12'h301, 32'h0, r, il);
        check("misa_read_legal", il, 0);
        check("misa_value", r, 32'h4000_0100);
        csr(RW, 12'h301, 32'h1, r, il);
        check("misa_write_illegal", il, 1);

        // reset wins over a same-cycle exception
        exc_valid = 1'b1;
        exc_pc = 32'h300;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exc_valid = 1'b0;
        check("rst_mid_mepc", mepc, 0);
        check("rst_mid_mstatus", mstatus, 32'h1880);

        // random CSR traffic against a value/mask model
        mdl[0] = 0;
        mdl[1] = 0;
        mdl[2] = SCR;
        mdl[3] = 0;
        mdl[4] = 0;
        mdl[5] = 0;
        mdl[6] = 0;
        mip_m = 0;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 6);
            op = 2'($urandom_range(1, 3));
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            lines = 3'($urandom_range(0, 7));
            irq_mext = lines[2];
            irq_msoft = lines[1];
            irq_mtimer = lines[0];
            wr = (op == RW) || (wd != 0);
            if (k == 6) begin
                exp_rd = wr ? 32'h0 : mip_m;
            end else begin
                exp_rd = mdl[k];
                if (wr) begin
                    case (op)
                        RS:      nv = mdl[k] | wd;
                        RC:      nv = mdl[k] & ~wd;
                        default: nv = wd;
                    endcase
                    mdl[k] = nv & rmask[k];
                end
            end
            csr(op, raddr[k], wd, r, il);
            check($sformatf("rand_rd_%0h", raddr[k]), r, exp_rd);
            check($sformatf("rand_il_%0h", raddr[k]), il, (k == 6) && wr);
            mip_m = (lines[2] ? 32'h800 : 0) | (lines[1] ? 32'h8 : 0) | (lines[0] ? 32'h80 : 0);
        end
        irq_mext = 1'b0;
        irq_msoft = 1'b0;
        irq_mtimer = 1'b0;
        check("rand_irq_disabled", irq_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
